// File: rtl/read_return_serializer.sv
// -----------------------------------------------------------------------------
// read_return_serializer
//
// Return-path transmitter of the frontend scheduler. Each read command issued
// to the backend pushes its {request id, core number} tag into a tag FIFO.
// Words returned by the backend, in command order, are held in a small data
// buffer. The head word is paired with the head tag and sent to the
// interconnection as four FE_W-bit beats, least-significant slice first. The
// beats use a valid/ready handshake, and a last flag marks the fourth beat.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_tag_push_valid             read command issued; push {i_tag_req_id, i_tag_core_num}
//   o_tag_full                   tag FIFO holds TAG_DEPTH entries
//   o_tag_overflow               sticky: tag push attempted while full
//   i_returned_data_valid        backend word valid (i_returned_data)
//   o_frontend_receive_ready     data buffer can accept a word
//   i_interconnection_ready      interconnection accepts the current beat
//   o_scheduler_request_valid    beat valid
//   o_scheduler_read_data        beat data
//   o_scheduler_read_data_last   final beat of a word
//   o_scheduler_request_id       id of the word being sent
//   o_scheduler_core_num         core of the word being sent
// -----------------------------------------------------------------------------
module read_return_serializer #(
  parameter int FE_W       = 256,
  parameter int BE_W       = 1024,
  parameter int ID_W       = 4,
  parameter int CORE_W     = 2,
  parameter int TAG_DEPTH  = 8,
  parameter int DATA_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tag_push_valid,
  input  logic [ID_W-1:0]   i_tag_req_id,
  input  logic [CORE_W-1:0] i_tag_core_num,
  output logic              o_tag_full,
  output logic              o_tag_overflow,
  input  logic              i_returned_data_valid,
  input  logic [BE_W-1:0]   i_returned_data,
  output logic              o_frontend_receive_ready,
  input  logic              i_interconnection_ready,
  output logic              o_scheduler_request_valid,
  output logic [FE_W-1:0]   o_scheduler_read_data,
  output logic              o_scheduler_read_data_last,
  output logic [ID_W-1:0]   o_scheduler_request_id,
  output logic [CORE_W-1:0] o_scheduler_core_num
);

  localparam int TAG_PTR_W  = $clog2(TAG_DEPTH);
  localparam int TAG_CNT_W  = TAG_PTR_W + 1;
  localparam int DATA_PTR_W = $clog2(DATA_DEPTH);
  localparam int DATA_CNT_W = DATA_PTR_W + 1;

  localparam logic [TAG_CNT_W-1:0]  TAG_FULL_CNT  = TAG_CNT_W'(TAG_DEPTH);
  localparam logic [DATA_CNT_W-1:0] DATA_FULL_CNT = DATA_CNT_W'(DATA_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Select one FE_W slice of a backend word; beat 0 is the least-significant slice.
  function automatic logic [FE_W-1:0] beat_slice(input logic [BE_W-1:0] word,
                                                 input logic [1:0]      beat);
    case (beat)
      2'd0:    beat_slice = word[0*FE_W +: FE_W];
      2'd1:    beat_slice = word[1*FE_W +: FE_W];
      2'd2:    beat_slice = word[2*FE_W +: FE_W];
      2'd3:    beat_slice = word[3*FE_W +: FE_W];
      default: beat_slice = word[0*FE_W +: FE_W];
    endcase
  endfunction

  // Storage
  logic [ID_W-1:0]       tag_id_mem_r   [TAG_DEPTH];
  logic [CORE_W-1:0]     tag_core_mem_r [TAG_DEPTH];
  logic [BE_W-1:0]       data_mem_r     [DATA_DEPTH];

  logic [TAG_PTR_W-1:0]  tag_wr_ptr_r, tag_rd_ptr_r, tag_rd_nxt_s;
  logic [TAG_CNT_W-1:0]  tag_cnt_r, tag_cnt_nxt_s;
  logic [DATA_PTR_W-1:0] data_wr_ptr_r, data_rd_ptr_r, data_rd_nxt_s;
  logic [DATA_CNT_W-1:0] data_cnt_r, data_cnt_nxt_s;

  logic                  tag_full_r, tag_overflow_r, rx_ready_r;
  state_e                state_r;
  logic [1:0]            beat_r;
  logic                  valid_r, last_r;
  logic [FE_W-1:0]       data_out_r;
  logic [ID_W-1:0]       id_out_r;
  logic [CORE_W-1:0]     core_out_r;

  logic                  tag_push_s, data_wr_s, beat_fire_s, pop_s;
  logic                  tag_push_full_s;

  // Pushes are gated on the registered counts; a full FIFO never looks ahead to a same-cycle pop.
  assign tag_push_s      = i_tag_push_valid && (tag_cnt_r != TAG_FULL_CNT);
  assign tag_push_full_s = i_tag_push_valid && (tag_cnt_r == TAG_FULL_CNT);
  assign data_wr_s       = i_returned_data_valid && (data_cnt_r != DATA_FULL_CNT);
  assign beat_fire_s     = valid_r && i_interconnection_ready;
  assign pop_s           = beat_fire_s && (beat_r == 2'd3);
  assign tag_rd_nxt_s    = tag_rd_ptr_r + TAG_PTR_W'(1);
  assign data_rd_nxt_s   = data_rd_ptr_r + DATA_PTR_W'(1);

  // Next occupancy of both FIFOs from this cycle's push/write and pop.
  always_comb begin
    tag_cnt_nxt_s  = tag_cnt_r;
    data_cnt_nxt_s = data_cnt_r;
    if (tag_push_s && !pop_s) begin
      tag_cnt_nxt_s = tag_cnt_r + TAG_CNT_W'(1);
    end else if (!tag_push_s && pop_s) begin
      tag_cnt_nxt_s = tag_cnt_r - TAG_CNT_W'(1);
    end else begin
      tag_cnt_nxt_s = tag_cnt_r;
    end
    if (data_wr_s && !pop_s) begin
      data_cnt_nxt_s = data_cnt_r + DATA_CNT_W'(1);
    end else if (!data_wr_s && pop_s) begin
      data_cnt_nxt_s = data_cnt_r - DATA_CNT_W'(1);
    end else begin
      data_cnt_nxt_s = data_cnt_r;
    end
  end

  // FIFO payload storage; contents are qualified by the counts, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (tag_push_s) begin
      tag_id_mem_r[tag_wr_ptr_r]   <= i_tag_req_id;
      tag_core_mem_r[tag_wr_ptr_r] <= i_tag_core_num;
    end
    if (data_wr_s) begin
      data_mem_r[data_wr_ptr_r] <= i_returned_data;
    end
  end

  // FIFO pointers, counts and the status flags derived from them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_wr_ptr_r   <= '0;
      tag_rd_ptr_r   <= '0;
      tag_cnt_r      <= '0;
      data_wr_ptr_r  <= '0;
      data_rd_ptr_r  <= '0;
      data_cnt_r     <= '0;
      tag_full_r     <= 1'b0;
      tag_overflow_r <= 1'b0;
      rx_ready_r     <= 1'b1;
    end else begin
      if (tag_push_s) begin
        tag_wr_ptr_r <= tag_wr_ptr_r + TAG_PTR_W'(1);
      end
      if (data_wr_s) begin
        data_wr_ptr_r <= data_wr_ptr_r + DATA_PTR_W'(1);
      end
      if (pop_s) begin
        tag_rd_ptr_r  <= tag_rd_nxt_s;
        data_rd_ptr_r <= data_rd_nxt_s;
      end
      if (tag_push_full_s) begin
        tag_overflow_r <= 1'b1;
      end
      tag_cnt_r  <= tag_cnt_nxt_s;
      data_cnt_r <= data_cnt_nxt_s;
      tag_full_r <= (tag_cnt_nxt_s == TAG_FULL_CNT);
      rx_ready_r <= (data_cnt_nxt_s < DATA_FULL_CNT);
    end
  end

  // Serializer FSM with registered beat outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      beat_r     <= 2'd0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
      data_out_r <= '0;
      id_out_r   <= '0;
      core_out_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((data_cnt_r != '0) && (tag_cnt_r != '0)) begin
            state_r    <= ST_SEND;
            beat_r     <= 2'd0;
            valid_r    <= 1'b1;
            last_r     <= 1'b0;
            data_out_r <= beat_slice(data_mem_r[data_rd_ptr_r], 2'd0);
            id_out_r   <= tag_id_mem_r[tag_rd_ptr_r];
            core_out_r <= tag_core_mem_r[tag_rd_ptr_r];
          end
        end
        ST_SEND: begin
          if (beat_fire_s) begin
            if (beat_r != 2'd3) begin
              beat_r     <= beat_r + 2'd1;
              data_out_r <= beat_slice(data_mem_r[data_rd_ptr_r], beat_r + 2'd1);
              last_r     <= (beat_r == 2'd2);
            end else if ((data_cnt_r > DATA_CNT_W'(1)) && (tag_cnt_r > TAG_CNT_W'(1))) begin
              // Second pair already queued: start its beat 0 straight away.
              beat_r     <= 2'd0;
              last_r     <= 1'b0;
              data_out_r <= beat_slice(data_mem_r[data_rd_nxt_s], 2'd0);
              id_out_r   <= tag_id_mem_r[tag_rd_nxt_s];
              core_out_r <= tag_core_mem_r[tag_rd_nxt_s];
            end else begin
              state_r <= ST_IDLE;
              beat_r  <= 2'd0;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          beat_r  <= 2'd0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tag_full                 = tag_full_r;
  assign o_tag_overflow             = tag_overflow_r;
  assign o_frontend_receive_ready   = rx_ready_r;
  assign o_scheduler_request_valid  = valid_r;
  assign o_scheduler_read_data      = data_out_r;
  assign o_scheduler_read_data_last = last_r;
  assign o_scheduler_request_id     = id_out_r;
  assign o_scheduler_core_num       = core_out_r;

endmodule

// File: tb/tb_read_return_serializer.sv
module tb_read_return_serializer;

  localparam int FE_W   = 256;
  localparam int BE_W   = 1024;
  localparam int ID_W   = 4;
  localparam int CORE_W = 2;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_tag_push_valid;
  logic [ID_W-1:0]   i_tag_req_id;
  logic [CORE_W-1:0] i_tag_core_num;
  logic              o_tag_full;
  logic              o_tag_overflow;
  logic              i_returned_data_valid;
  logic [BE_W-1:0]   i_returned_data;
  logic              o_frontend_receive_ready;
  logic              i_interconnection_ready;
  logic              o_scheduler_request_valid;
  logic [FE_W-1:0]   o_scheduler_read_data;
  logic              o_scheduler_read_data_last;
  logic [ID_W-1:0]   o_scheduler_request_id;
  logic [CORE_W-1:0] o_scheduler_core_num;

  read_return_serializer #(
    .FE_W(FE_W), .BE_W(BE_W), .ID_W(ID_W), .CORE_W(CORE_W),
    .TAG_DEPTH(8), .DATA_DEPTH(2)
  ) dut (
    .i_clk                      (i_clk),
    .i_rst_n                    (i_rst_n),
    .i_tag_push_valid           (i_tag_push_valid),
    .i_tag_req_id               (i_tag_req_id),
    .i_tag_core_num             (i_tag_core_num),
    .o_tag_full                 (o_tag_full),
    .o_tag_overflow             (o_tag_overflow),
    .i_returned_data_valid      (i_returned_data_valid),
    .i_returned_data            (i_returned_data),
    .o_frontend_receive_ready   (o_frontend_receive_ready),
    .i_interconnection_ready    (i_interconnection_ready),
    .o_scheduler_request_valid  (o_scheduler_request_valid),
    .o_scheduler_read_data      (o_scheduler_read_data),
    .o_scheduler_read_data_last (o_scheduler_read_data_last),
    .o_scheduler_request_id     (o_scheduler_request_id),
    .o_scheduler_core_num       (o_scheduler_core_num)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [FE_W-1:0] obs, input logic [FE_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queues of pending words and tags, plus the word in flight.
  logic [BE_W-1:0]        m_data_q[$];
  logic [ID_W+CORE_W-1:0] m_tag_q[$];
  bit                     m_send;
  int                     m_beat;
  bit                     m_ovf;

  function automatic logic [BE_W-1:0] rand_word();
    logic [BE_W-1:0] w;
    for (int i = 0; i < BE_W/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [BE_W-1:0] nibble_word();
    logic [BE_W-1:0] w;
    logic [3:0]      nib;
    for (int b = 0; b < 4; b++) begin
      nib = 4'hA + 4'(b);
      w[b*FE_W +: FE_W] = {64{nib}};
    end
    return w;
  endfunction

  task automatic model_reset();
    m_data_q.delete();
    m_tag_q.delete();
    m_send = 1'b0;
    m_beat = 0;
    m_ovf  = 1'b0;
  endtask

  // Apply one clock edge to the model using the inputs as driven before the edge.
  task automatic model_edge();
    int dsz = m_data_q.size();
    int tsz = m_tag_q.size();
    bit pop = 1'b0;
    if (!m_send) begin
      if (dsz > 0 && tsz > 0) begin
        m_send = 1'b1;
        m_beat = 0;
      end
    end else if (i_interconnection_ready) begin
      if (m_beat < 3) begin
        m_beat++;
      end else begin
        pop = 1'b1;
        if (dsz > 1 && tsz > 1) m_beat = 0;
        else m_send = 1'b0;
      end
    end
    if (pop) begin
      void'(m_data_q.pop_front());
      void'(m_tag_q.pop_front());
    end
    if (i_tag_push_valid) begin
      if (tsz < 8) m_tag_q.push_back({i_tag_req_id, i_tag_core_num});
      else m_ovf = 1'b1;
    end
    if (i_returned_data_valid && dsz < 2) m_data_q.push_back(i_returned_data);
  endtask

  task automatic check_outputs();
    logic [BE_W-1:0]        hw;
    logic [ID_W+CORE_W-1:0] ht;
    check_eq("valid", FE_W'(o_scheduler_request_valid), FE_W'(m_send));
    check_eq("last", FE_W'(o_scheduler_read_data_last), FE_W'(m_send && m_beat == 3));
    check_eq("rx_ready", FE_W'(o_frontend_receive_ready), FE_W'(m_data_q.size() < 2));
    check_eq("tag_full", FE_W'(o_tag_full), FE_W'(m_tag_q.size() == 8));
    check_eq("overflow", FE_W'(o_tag_overflow), FE_W'(m_ovf));
    if (m_send) begin
      hw = m_data_q[0];
      ht = m_tag_q[0];
      check_eq("beat_data", o_scheduler_read_data, hw[m_beat*FE_W +: FE_W]);
      check_eq("req_id", FE_W'(o_scheduler_request_id), FE_W'(ht[ID_W+CORE_W-1:CORE_W]));
      check_eq("core_num", FE_W'(o_scheduler_core_num), FE_W'(ht[CORE_W-1:0]));
    end
  endtask

  task automatic drive(input bit push, input int id, input int core,
                       input bit dv, input logic [BE_W-1:0] d, input bit rdy);
    i_tag_push_valid        = push;
    i_tag_req_id            = ID_W'(id);
    i_tag_core_num          = CORE_W'(core);
    i_returned_data_valid   = dv;
    i_returned_data         = d;
    i_interconnection_ready = rdy;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge i_clk);
    if (i_rst_n) model_edge();
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic idle_steps(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 0, 1'b0, '0, rdy);
      step();
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    #2 i_rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
    #1;
    check_eq("rst_valid", FE_W'(o_scheduler_request_valid), FE_W'(1'b0));
    check_eq("rst_last", FE_W'(o_scheduler_read_data_last), FE_W'(1'b0));
    check_eq("rst_full", FE_W'(o_tag_full), FE_W'(1'b0));
    check_eq("rst_overflow", FE_W'(o_tag_overflow), FE_W'(1'b0));
    check_eq("rst_rx_ready", FE_W'(o_frontend_receive_ready), FE_W'(1'b1));
    check_eq("rst_data", o_scheduler_read_data, '0);
    check_eq("rst_id", FE_W'(o_scheduler_request_id), '0);
    check_eq("rst_core", FE_W'(o_scheduler_core_num), '0);
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    logic [FE_W-1:0] exp_a;
    i_rst_n = 1'b1;
    drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
    model_reset();
    @(negedge i_clk);
    async_reset();

    // Single word with recognisable slices A,B,C,D, id 5 / core 2.
    drive(1'b1, 5, 2, 1'b0, '0, 1'b1);        step();
    drive(1'b0, 0, 0, 1'b1, nibble_word(), 1'b1); step();
    drive(1'b0, 0, 0, 1'b0, '0, 1'b1);        step();
    exp_a = {64{4'hA}};
    check_eq("first_beat_A", o_scheduler_read_data, exp_a);
    check_eq("first_beat_id", FE_W'(o_scheduler_request_id), FE_W'(4'd5));
    idle_steps(6, 1'b1);

    // Back-to-back words, ids 1 and 2.
    drive(1'b1, 1, 0, 1'b1, rand_word(), 1'b1); step();
    drive(1'b1, 2, 1, 1'b1, rand_word(), 1'b1); step();
    idle_steps(12, 1'b1);

    // Backpressure during beat 1.
    drive(1'b1, 3, 3, 1'b1, rand_word(), 1'b0); step();
    idle_steps(2, 1'b1);
    idle_steps(3, 1'b0);
    idle_steps(6, 1'b1);

    // Data before its tag.
    drive(1'b0, 0, 0, 1'b1, rand_word(), 1'b1); step();
    idle_steps(5, 1'b1);
    drive(1'b1, 7, 1, 1'b0, '0, 1'b1); step();
    idle_steps(8, 1'b1);

    // Flow control: two words, a dropped third, then nine tags with no drain.
    drive(1'b0, 0, 0, 1'b1, rand_word(), 1'b0); step();
    drive(1'b0, 0, 0, 1'b1, rand_word(), 1'b0); step();
    drive(1'b0, 0, 0, 1'b1, rand_word(), 1'b0); step();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i + 1, i % 4, 1'b0, '0, 1'b0);
      step();
    end
    idle_steps(12, 1'b1);

    // Reset mid-word (after beat 1), then a fresh word.
    drive(1'b1, 9, 1, 1'b1, rand_word(), 1'b0); step();
    idle_steps(2, 1'b1);
    async_reset();
    drive(1'b1, 4, 3, 1'b1, rand_word(), 1'b1); step();
    idle_steps(8, 1'b1);

    // Randomised traffic with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) async_reset();
      drive(($urandom_range(0, 99) < 30), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 30), rand_word(), ($urandom_range(0, 99) < 70));
      step();
    end
    idle_steps(20, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_return_serializer.md
Name: read_return_serializer

Overview:
- Return-path transmitter of the frontend scheduler. Accepts 1024-bit read data returned by the backend controller in command order.
- Pairs each returned word with the {request id, core number} tag recorded when the read command was issued.
- Streams each word to the interconnection as four 256-bit beats with a last flag, under a valid/ready handshake.
- Sits between the backend data-return interface and the interconnection response interface (o_scheduler_request_valid and related outputs).

Parameters:
- FE_W, 256: frontend beat width.
- BE_W, 1024: backend word width; BE_W/FE_W = 4 beats.
- ID_W, 4: request id width (req_id_t).
- CORE_W, 2: core number width (core_num_t).
- TAG_DEPTH, 8: outstanding-read tag FIFO depth (power of 2).
- DATA_DEPTH, 2: returned-word buffer depth (power of 2).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_tag_push_valid  in  1  read command issued to backend; push tag
- i_tag_req_id  in  ID_W  id of issued read
- i_tag_core_num  in  CORE_W  core of issued read
- o_tag_full  out  1  tag FIFO holds TAG_DEPTH entries
- o_tag_overflow  out  1  sticky: push attempted while full
- i_returned_data_valid  in  1  backend data valid
- i_returned_data  in  BE_W  backend data word
- o_frontend_receive_ready  out  1  data buffer can accept a word
- i_interconnection_ready  in  1  interconnection accepts a beat
- o_scheduler_request_valid  out  1  beat valid
- o_scheduler_read_data  out  FE_W  beat data
- o_scheduler_read_data_last  out  1  final (4th) beat of a word
- o_scheduler_request_id  out  ID_W  tag id of current word
- o_scheduler_core_num  out  CORE_W  tag core of current word

Behaviour:
- Reset (async, active-low):
  - Both FIFOs are emptied and the FSM goes to IDLE.
  - o_scheduler_request_valid=0, o_scheduler_read_data_last=0, o_tag_full=0, o_tag_overflow=0, o_frontend_receive_ready=1.
  - Data, id and core outputs are 0.
  - Reset asserted mid-word discards the word and all pending tags; no partial word is resumed.
- Tag FIFO:
  - Pushes when i_tag_push_valid and not full.
  - A push while full is dropped and sets o_tag_overflow, which holds until reset.
  - o_tag_full = (count==TAG_DEPTH), registered count.
  - Push and pop in the same cycle are both honoured when count is between 1 and TAG_DEPTH-1. At count==TAG_DEPTH the push is dropped even if a pop occurs that cycle.
- Data buffer:
  - o_frontend_receive_ready = (count < DATA_DEPTH), from registered count.
  - A word is written on i_returned_data_valid && o_frontend_receive_ready.
  - Ready does not look ahead to a same-cycle pop.
  - A write in the cycle the buffer is full is the backend's violation; the word is dropped.
- FSM, states IDLE and SEND; 2-bit beat counter.
  - IDLE -> SEND at the edge when data count>0 and tag count>0 (both sampled from registers). The beat counter is set to 0.
  - Minimum latency: word written at edge k; valid is high after edge k+1, given a tag is present at k+1.
  - Data arriving before its tag waits in IDLE with no error.
  - In SEND, o_scheduler_request_valid=1.
  - Beat b outputs i_returned_data[FE_W*b +: FE_W] of the head word; beat 0 is the least-significant slice.
  - id and core come from the head tag.
  - o_scheduler_read_data_last=1 only when b==3.
- Beat advance:
  - A beat completes on valid && i_interconnection_ready.
  - Otherwise all beat outputs hold stable (no retraction, no change).
  - Beats 0-2 increment b.
  - Beat 3 pops the head data entry and the head tag together. If another data+tag pair is present after the pop (count>1 in both), stay in SEND with b=0 and no bubble; else go to IDLE.
- Ordering: strictly in order. Word n is paired with tag n.

Test Plan:
- Push tag (id=5, core=2); return word W with slices 0..3 = 0xA..,0xB..,0xC..,0xD.. (each FE_W-bit slice filled with that nibble), ready held 1 -> four consecutive valid beats A,B,C,D; last=1 only on D; id=5 and core=2 on all four beats; valid drops after D.
- Back-to-back: 2 tags (ids 1,2) + 2 words, ready=1 -> 8 contiguous beats with no idle cycle between beat 3 of id 1 and beat 0 of id 2.
- Backpressure: drop ready for 3 cycles during beat 1 -> data, last, id and core all held; beat 2 appears only after ready returns; total 4 handshakes.
- Data before tag: return word, push tag 5 cycles later -> valid stays 0 until the edge after the push; then normal 4-beat output.
- Flow control: 2 words with no tags -> o_frontend_receive_ready=0. Push 9 tags -> o_tag_full after 8; 9th push sets o_tag_overflow=1. Serialize both words -> 8 beats; tag count 6 remaining.
- Reset mid-word (after beat 1) -> valid=0 immediately; buffers empty; ready=1; overflow cleared; a new tag+word afterwards starts at beat 0.
